// File: rtl/seg_pkg.sv
// Shared types and constants for the six-digit multiplexed seven-segment scanner.
// Segment patterns are active-low (common anode), bit order g..a.
package seg_pkg;

    localparam int DIGITS = 6;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GHOST = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    // Decimal point is not part of the glyph; it is merged in by the scanner.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex digit to active-low seven-segment pattern (g..a).
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[hex];

endmodule

// File: rtl/seg_dyn_scan.sv
// Six-digit dynamic scan driver with anti-ghost blanking and frame-aligned data update.
// Optional macro SEG_DP_EN adds the per-digit decimal point input and storage.
//
// state | meaning
// IDLE  | scanning disabled, outputs blank, counters held at zero
// GHOST | start of a digit slot, outputs blank to let the previous digit turn off
// SHOW  | remainder of the slot, active digit driven
module seg_dyn_scan
    import seg_pkg::*;
#(
    parameter logic [15:0] CNT_MAX   = 16'd49_999,
    parameter logic [15:0] BLANK_CYC = 16'd500
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        en,
    input  logic [23:0] data_in,
`ifdef SEG_DP_EN
    input  logic [5:0]  dp_in,
`endif
    input  logic        data_valid,
    output logic        data_ready,
    output logic [5:0]  sel,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam logic [2:0] IDX_LAST = 3'(DIGITS - 1);

    scan_state_e state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [2:0]  idx, idx_nx;

    logic [23:0] pend_data, active_data;
    logic        pend_full, pend_full_nx;
    logic        accept, apply_pend;
    logic [3:0]  digit_nx;
    logic [6:0]  glyph_nx;
    logic        dp_bit_nx;

`ifdef SEG_DP_EN
    logic [5:0] pend_dp, active_dp;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = GHOST;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
                default: begin
                    if (cnt == CNT_MAX) begin
                        state_nx = GHOST;
                        cnt_nx   = '0;
                        idx_nx   = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
                    end else begin
                        // Blank spans cnt 0..BLANK_CYC so the registered outputs light from BLANK_CYC+1.
                        state_nx = (cnt >= BLANK_CYC) ? SHOW : GHOST;
                        cnt_nx   = cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    assign frame_done = (state != IDLE) && (cnt == CNT_MAX) && (idx == IDX_LAST);

    assign accept     = data_valid && data_ready;
    assign apply_pend = frame_done && pend_full;

    // accept requires an empty buffer, so it never coincides with apply_pend
    always_comb begin
        pend_full_nx = pend_full;
        if (apply_pend) begin
            pend_full_nx = 1'b0;
        end else if (accept) begin
            pend_full_nx = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            pend_full   <= 1'b0;
            data_ready  <= 1'b1;
            pend_data   <= '0;
            active_data <= '0;
        end else begin
            pend_full  <= pend_full_nx;
            data_ready <= !pend_full_nx;
            if (apply_pend) begin
                active_data <= pend_data;
            end
            if (accept) begin
                pend_data <= data_in;
            end
        end
    end

`ifdef SEG_DP_EN
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            pend_dp   <= '0;
            active_dp <= '0;
        end else begin
            if (apply_pend) begin
                active_dp <= pend_dp;
            end
            if (accept) begin
                pend_dp <= dp_in;
            end
        end
    end
    assign dp_bit_nx = ~active_dp[idx_nx];
`else
    assign dp_bit_nx = 1'b1;
`endif

    assign digit_nx = active_data[{idx_nx, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .hex   (digit_nx),
        .seg_n (glyph_nx)
    );

    // Output stage is loaded from the next-state view so it lines up with the state register.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sel <= 6'h00;
            seg <= SEG_BLANK;
        end else if (state_nx == SHOW) begin
            sel <= 6'h01 << idx_nx;
            seg <= {dp_bit_nx, glyph_nx};
        end else begin
            sel <= 6'h00;
            seg <= SEG_BLANK;
        end
    end

endmodule
